// File: rtl/preg_reclaim_unit_pkg.sv
// Shared sizing, types and reset helpers for the physical-register reclaim unit.
// Contents: register-file sizes, reclaim FIFO depth, RAT type, FSM state enum,
//           identity-RAT helper and the reset value of the in-use bitmap.
package preg_reclaim_unit_pkg;
  localparam int NUM_A_REGS    = 32;
  localparam int NUM_P_REGS    = 64;
  localparam int ARN_WIDTH     = $clog2(NUM_A_REGS);
  localparam int PRN_WIDTH     = $clog2(NUM_P_REGS);
  localparam int RCL_DEPTH     = 8;
  localparam int RCL_CNT_WIDTH = $clog2(RCL_DEPTH) + 1;

  typedef logic [ARN_WIDTH-1:0] arn_t;
  typedef logic [PRN_WIDTH-1:0] prn_t;
  typedef prn_t [NUM_A_REGS-1:0] rat_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RAT_WALK,
    S_FL_WALK,
    S_DONE
  } reclaim_state_e;

  // Architectural reg i maps to physical reg i out of reset.
  localparam logic [NUM_P_REGS-1:0] IN_USE_RESET =
    {{(NUM_P_REGS-NUM_A_REGS){1'b0}}, {NUM_A_REGS{1'b1}}};

  function automatic rat_t identity_rat();
    rat_t r;
    for (int i = 0; i < NUM_A_REGS; i++) r[i] = prn_t'(i);
    return r;
  endfunction
endpackage

// File: rtl/preg_reclaim_unit_if.sv
// Bundle of the ROB-commit, free-list push, flush and spec-RAT recovery signals.
// master: ROB / rename side (drives commit, free_ready, flush_req).
// slave : preg_reclaim_unit (drives commit_ready, free port, recovery outputs).
interface preg_reclaim_unit_if;
  import preg_reclaim_unit_pkg::*;

  logic commit_valid;
  logic commit_ready;
  logic commit_has_rd;
  arn_t commit_arch_rd;
  prn_t commit_new_preg;
  prn_t commit_old_preg;
  logic free_valid;
  logic free_ready;
  prn_t free_preg;
  logic free_clear;
  logic flush_req;
  logic recov_valid;
  arn_t recov_arch;
  prn_t recov_preg;
  logic recov_busy;
  logic recov_done;

  modport master (
    output commit_valid, commit_has_rd, commit_arch_rd, commit_new_preg, commit_old_preg,
    output free_ready, flush_req,
    input  commit_ready, free_valid, free_preg, free_clear,
    input  recov_valid, recov_arch, recov_preg, recov_busy, recov_done
  );

  modport slave (
    input  commit_valid, commit_has_rd, commit_arch_rd, commit_new_preg, commit_old_preg,
    input  free_ready, flush_req,
    output commit_ready, free_valid, free_preg, free_clear,
    output recov_valid, recov_arch, recov_preg, recov_busy, recov_done
  );
endinterface

// File: rtl/preg_reclaim_fifo.sv
// Synchronous FIFO holding superseded pregs awaiting return to the free list.
// Latency: push visible at head the cycle after; push+pop in one cycle keeps count.
// Backpressure: caller gates push on count < DEPTH and pop on count != 0; flush wins.
// Ports: clk/rst, push/push_dat, pop, flush, head (oldest entry), count (occupancy).
module preg_reclaim_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 6,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Power-of-two depth: pointers wrap naturally.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/preg_reclaim_unit.sv
// Retirement RAT + preg reclaim; on flush rebuilds spec RAT and free list from committed state.
// Latency: commit -> free_valid 1 cycle; recovery 1+NUM_A_REGS+NUM_P_REGS+1 cycles w/o stalls.
// Backpressure: commit_ready drops when reclaim FIFO full or recovering; FL walk waits on free_ready.
// Ports: clk, rst (sync, active-high), bus (slave modport: commit, free push, flush, recovery).
module preg_reclaim_unit
  import preg_reclaim_unit_pkg::*;
(
  input logic                clk,
  input logic                rst,
  preg_reclaim_unit_if.slave bus
);
  reclaim_state_e           state_q, state_d;
  prn_t                     idx_q, idx_d;
  rat_t                     ret_rat;
  logic [NUM_P_REGS-1:0]    in_use;
  logic                     fifo_push, fifo_pop, fifo_flush;
  prn_t                     fifo_head;
  logic [RCL_CNT_WIDTH-1:0] fifo_count;
  logic                     fifo_full, fifo_empty, commit_fire;

  assign fifo_full   = (fifo_count == RCL_CNT_WIDTH'(RCL_DEPTH));
  assign fifo_empty  = (fifo_count == '0);
  assign commit_fire = bus.commit_valid && bus.commit_ready;

  preg_reclaim_fifo #(
    .DEPTH (RCL_DEPTH),
    .WIDTH (PRN_WIDTH),
    .CNT_W (RCL_CNT_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (bus.commit_old_preg),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    fifo_push        = 1'b0;
    fifo_pop         = 1'b0;
    fifo_flush       = 1'b0;
    bus.commit_ready = 1'b0;
    bus.free_valid   = 1'b0;
    bus.free_preg    = '0;
    bus.free_clear   = 1'b0;
    bus.recov_valid  = 1'b0;
    bus.recov_arch   = '0;
    bus.recov_preg   = '0;
    bus.recov_busy   = (state_q != S_IDLE);
    bus.recov_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.commit_ready = !fifo_full;
        bus.free_valid   = !fifo_empty;
        bus.free_preg    = fifo_head;
        fifo_pop         = !fifo_empty && bus.free_ready;
        fifo_push        = bus.commit_valid && !fifo_full && bus.commit_has_rd;
        // A same-cycle commit is older than the flush and is still applied.
        if (bus.flush_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        // Pending FIFO entries are not in use, so FL_WALK re-offers them.
        bus.free_clear = 1'b1;
        fifo_flush     = 1'b1;
        state_d        = S_RAT_WALK;
        idx_d          = '0;
      end
      S_RAT_WALK: begin
        bus.recov_valid = 1'b1;
        bus.recov_arch  = idx_q[ARN_WIDTH-1:0];
        bus.recov_preg  = ret_rat[idx_q[ARN_WIDTH-1:0]];
        if (idx_q == PRN_WIDTH'(NUM_A_REGS - 1)) begin
          state_d = S_FL_WALK;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + PRN_WIDTH'(1);
        end
      end
      S_FL_WALK: begin
        // In-use pregs are skipped in one cycle; free ones wait for free_ready.
        if (!in_use[idx_q]) begin
          bus.free_valid = 1'b1;
          bus.free_preg  = idx_q;
        end
        if (in_use[idx_q] || bus.free_ready) begin
          if (idx_q == PRN_WIDTH'(NUM_P_REGS - 1)) state_d = S_DONE;
          else                                    idx_d   = idx_q + PRN_WIDTH'(1);
        end
      end
      S_DONE: begin
        bus.recov_done = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ret_rat <= identity_rat();
      in_use  <= IN_USE_RESET;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (commit_fire && bus.commit_has_rd) begin
        ret_rat[bus.commit_arch_rd]  <= bus.commit_new_preg;
        in_use[bus.commit_old_preg]  <= 1'b0;
        in_use[bus.commit_new_preg]  <= 1'b1;
      end
    end
  end

  a_in_use_count: assert property (@(posedge clk) disable iff (rst)
    $countones(in_use) == NUM_A_REGS);
  a_old_ne_new: assert property (@(posedge clk) disable iff (rst)
    (commit_fire && bus.commit_has_rd) |-> (bus.commit_old_preg != bus.commit_new_preg));
  a_flush_idle: assert property (@(posedge clk) disable iff (rst)
    bus.flush_req |-> (state_q == S_IDLE));
endmodule

// File: tb/tb_preg_reclaim_unit.sv
module tb_preg_reclaim_unit;
  import preg_reclaim_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference model: committed map, in-use set, queue of superseded pregs in commit order.
  int   m_rat [NUM_A_REGS];
  bit   m_inuse [NUM_P_REGS];
  int   m_fifo [$];

  preg_reclaim_unit_if bus();

  preg_reclaim_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_A_REGS; i++) m_rat[i] = i;
    for (int p = 0; p < NUM_P_REGS; p++) m_inuse[p] = (p < NUM_A_REGS);
    m_fifo.delete();
  endtask

  task automatic drive_idle();
    bus.commit_valid    = 1'b0;
    bus.commit_has_rd   = 1'b0;
    bus.commit_arch_rd  = '0;
    bus.commit_new_preg = '0;
    bus.commit_old_preg = '0;
    bus.free_ready      = 1'b0;
    bus.flush_req       = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},   bus.recov_busy,   0);
    chk({tag, "_fvld"},   bus.free_valid,   0);
    chk({tag, "_cready"}, bus.commit_ready, 1);
    chk({tag, "_fclr"},   bus.free_clear,   0);
    chk({tag, "_rvld"},   bus.recov_valid,  0);
    chk({tag, "_rdone"},  bus.recov_done,   0);
  endtask

  function automatic bit in_fifo(input int p);
    foreach (m_fifo[k]) if (m_fifo[k] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick_new();
    int c;
    do c = $urandom_range(0, NUM_P_REGS - 1); while (m_inuse[c] || in_fifo(c));
    return c;
  endfunction

  // One IDLE-state cycle: check outputs against model, drive inputs, advance model and clock.
  task automatic idle_cycle(input bit vld, input bit has_rd, input int rd, input int nw,
                            input int old, input bit flush, input bit frdy);
    bit m_rdy, m_fv;
    m_rdy = (m_fifo.size() < RCL_DEPTH);
    m_fv  = (m_fifo.size() != 0);
    chk("idle_busy",    bus.recov_busy,   0);
    chk("commit_ready", bus.commit_ready, m_rdy);
    chk("free_valid",   bus.free_valid,   m_fv);
    if (m_fv) chk("free_preg", bus.free_preg, m_fifo[0]);
    bus.commit_valid    = vld;
    bus.commit_has_rd   = has_rd;
    bus.commit_arch_rd  = arn_t'(rd);
    bus.commit_new_preg = prn_t'(nw);
    bus.commit_old_preg = prn_t'(old);
    bus.flush_req       = flush;
    bus.free_ready      = frdy;
    if (m_fv && frdy) void'(m_fifo.pop_front());
    if (vld && m_rdy && has_rd) begin
      m_rat[rd]    = nw;
      m_inuse[old] = 1'b0;
      m_inuse[nw]  = 1'b1;
      m_fifo.push_back(old);
    end
    tick();
    drive_idle();
  endtask

  task automatic legal_cycle(input bit vld, input bit has_rd, input bit frdy);
    int rd, nw;
    rd = $urandom_range(0, NUM_A_REGS - 1);
    nw = pick_new();
    idle_cycle(vld, has_rd, rd, nw, m_rat[rd], 1'b0, frdy);
  endtask

  // Called with the DUT in CLEAR (the cycle after flush was taken).
  task automatic run_recovery(input bit toggle);
    int  exp_q [$];
    int  got_q [$];
    int  cyc;
    bit  done;
    for (int p = 0; p < NUM_P_REGS; p++) if (!m_inuse[p]) exp_q.push_back(p);
    chk("clr_pulse",  bus.free_clear,   1);
    chk("clr_busy",   bus.recov_busy,   1);
    chk("clr_cready", bus.commit_ready, 0);
    tick();
    for (int i = 0; i < NUM_A_REGS; i++) begin
      chk("walk_vld",  bus.recov_valid, 1);
      chk("walk_arch", bus.recov_arch,  i);
      chk("walk_preg", bus.recov_preg,  m_rat[i]);
      tick();
    end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 1000) begin
      if (bus.recov_done) done = 1'b1;
      else begin
        bus.free_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.free_valid && bus.free_ready) got_q.push_back(int'(bus.free_preg));
        tick();
        cyc++;
      end
    end
    chk("done_seen", done, 1);
    if (!toggle) chk("fl_walk_len", cyc, NUM_P_REGS);
    chk("free_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk("free_order", (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
    chk("done_busy", bus.recov_busy, 1);
    chk("done_fvld", bus.free_valid, 0);
    bus.free_ready = 1'b0;
    tick();
    check_reset_outputs("post_recov");
    m_fifo.delete();
  endtask

  task automatic start_flush();
    idle_cycle(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    drive_idle();
    model_reset();

    // Reset values.
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Flush straight from reset: identity RAT, frees 32..63.
    start_flush();
    run_recovery(1'b0);

    // Commit rd=5 new=40 old=5; preg 5 offered the following cycle.
    idle_cycle(1'b1, 1'b1, 5, 40, 5, 1'b0, 1'b1);
    idle_cycle(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle_cycle(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);

    // Commit in the same cycle as the flush is applied first.
    idle_cycle(1'b1, 1'b1, 3, 33, 3, 1'b1, 1'b0);
    run_recovery(1'b0);

    // Fill the reclaim FIFO, see backpressure, release one entry, then drain in order.
    for (int i = 0; i < RCL_DEPTH; i++) legal_cycle(1'b1, 1'b1, 1'b0);
    legal_cycle(1'b1, 1'b1, 1'b0);
    legal_cycle(1'b0, 1'b0, 1'b1);
    legal_cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < RCL_DEPTH + 1; i++) legal_cycle(1'b0, 1'b0, 1'b1);

    // Random traffic, then recovery with free_ready toggling.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 80; i++)
        legal_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                    1'($urandom_range(0, 2) == 0));
      start_flush();
      run_recovery(1'b1);
    end

    // Reset during RAT_WALK at idx 10 aborts immediately.
    for (int i = 0; i < 20; i++) legal_cycle(1'b1, 1'b1, 1'b1);
    start_flush();
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("abort_arch", bus.recov_arch, 10);
    chk("abort_rvld", bus.recov_valid, 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("abort");
    rst = 1'b0;
    model_reset();
    tick();
    check_reset_outputs("abort_rel");

    // Committed state after the abort is the reset state again.
    start_flush();
    run_recovery(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
